// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: FSM states and the buffered result entry.
package commit_unit_pkg;

  localparam int unsigned COMMIT_W = 71;

  typedef enum logic [1:0] {
    CU_RUN   = 2'b00,
    CU_DRAIN = 2'b01,
    CU_HALT  = 2'b10
  } cu_state_e;

  typedef struct packed {
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        ebreak;
  } commit_entry_t;

endpackage

// File: rtl/commit_fifo.sv
// In-order result buffer; only pointers and occupancy are reset, storage is not.
module commit_fifo
  import commit_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  commit_entry_t wdata,
  input  logic          pop,
  output commit_entry_t rdata,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  commit_entry_t   mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/commit_unit.sv
// Write-back/commit stage: buffers EXU results and retires them in order as
// single-cycle regfile commit pulses; halts after an ebreak retires.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exu_valid_i,
  output logic        exu_ready_o,
  input  logic        exu_wena_i,
  input  logic [4:0]  exu_waddr_i,
  input  logic [31:0] exu_wdata_i,
  input  logic [31:0] exu_pc_i,
  input  logic        exu_ebreak_i,
  input  logic        commit_ready_i,
  output logic        commit_valid_o,
  output logic        commit_wena_o,
  output logic [4:0]  commit_waddr_o,
  output logic [31:0] commit_wdata_o,
  output logic [31:0] commit_pc_o,
  output logic        halt_o,
  output logic [63:0] retired_o
);

  cu_state_e     state;
  commit_entry_t in_entry;
  commit_entry_t head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign in_entry = '{wena:   exu_wena_i,
                      waddr:  exu_waddr_i,
                      wdata:  exu_wdata_i,
                      pc:     exu_pc_i,
                      ebreak: exu_ebreak_i};

  assign exu_ready_o = (state == CU_RUN) && !full;
  assign push        = exu_valid_i && exu_ready_o;
  assign pop         = !empty && commit_ready_i && (state != CU_HALT);

  commit_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (in_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // x0 writes keep wena=1 so the scoreboard's Busy[0] gets cleared downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= CU_RUN;
      commit_valid_o <= 1'b0;
      commit_wena_o  <= 1'b0;
      commit_waddr_o <= '0;
      commit_wdata_o <= '0;
      commit_pc_o    <= '0;
      halt_o         <= 1'b0;
      retired_o      <= '0;
    end else begin
      commit_valid_o <= pop;
      if (pop) begin
        commit_wena_o  <= head.wena;
        commit_waddr_o <= head.waddr;
        commit_wdata_o <= head.wdata;
        commit_pc_o    <= head.pc;
        retired_o      <= retired_o + 64'd1;
      end else begin
        commit_wena_o  <= 1'b0;
      end
      halt_o <= (state == CU_HALT);
      case (state)
        CU_RUN:   if (push && exu_ebreak_i) state <= CU_DRAIN;
        CU_DRAIN: if (pop && head.ebreak)   state <= CU_HALT;
        CU_HALT:  state <= CU_HALT;
        default:  state <= CU_RUN;
      endcase
    end
  end

endmodule
